// File: rtl/hist_pkg.sv
// Shared constants and types for the histogram read-modify-write front end.
package hist_pkg;

  localparam int NUM_BINS = 32;
  localparam int BIN_W    = $clog2(NUM_BINS);
  localparam int DATA_W   = 32;
  localparam int WEIGHT_W = 8;

  typedef logic [BIN_W-1:0]    bin_t;
  typedef logic [DATA_W-1:0]   count_t;
  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR
  } upd_state_t;

endpackage

// File: rtl/hist_add_sat.sv
// Count + weight adder with overflow detect; HIST_SAT_EN selects clamping
// to all ones instead of modulo wrap.
module hist_add_sat
  import hist_pkg::*;
(
  input  count_t  operand,
  input  weight_t weight,
  output count_t  sum,
  output logic    ovf
);

  logic [DATA_W:0] wide;

  assign wide = {1'b0, operand} + {{(DATA_W + 1 - WEIGHT_W){1'b0}}, weight};
  assign ovf  = wide[DATA_W];

`ifdef HIST_SAT_EN
  assign sum = ovf ? '1 : wide[DATA_W-1:0];
`else
  assign sum = wide[DATA_W-1:0];
`endif

endmodule

// File: rtl/hist_update.sv
// Two-stage read-modify-write histogram updater with same-bin forwarding and
// a full clear sweep. Optional macro HIST_SAT_EN: saturating adds.
module hist_update
  import hist_pkg::*;
(
  input  logic    clock,
  input  logic    ctrl_reset,
  input  logic    in_valid,
  output logic    in_ready,
  input  bin_t    in_bin,
  input  weight_t in_weight,
  input  logic    clear_req,
  output logic    busy,
  output bin_t    ctrl_readRegA,
  input  count_t  data_readRegA,
  output logic    ctrl_writeEnable,
  output bin_t    ctrl_writeReg,
  output count_t  data_writeReg,
  output logic    sat_flag
);

  localparam bit BIN_FULL = (NUM_BINS == (1 << BIN_W));

  upd_state_t state_reg, state_next;
  bin_t       clr_cnt_reg, clr_cnt_next;
  logic       clear_done;

  logic       s1_valid_reg;
  bin_t       s1_bin_reg;
  weight_t    s1_weight_reg;
  logic       s2_valid_reg;
  bin_t       s2_bin_reg;
  count_t     s2_sum_reg;
  logic       sat_flag_reg;

  logic       bin_ok;
  logic       accept;
  logic       forward;
  count_t     operand;
  count_t     add_sum;
  logic       add_ovf;

  assign in_ready = (state_reg == RUN) && !clear_req;
  // Out-of-range bins only exist when NUM_BINS is not a power of two.
  assign bin_ok   = BIN_FULL || (int'(in_bin) < NUM_BINS);
  assign accept   = in_valid && in_ready && bin_ok;

  // The file's write lands mid-cycle, so a same-bin hit in S1 must take S2's sum.
  assign forward  = s1_valid_reg && s2_valid_reg && (s1_bin_reg == s2_bin_reg);
  assign operand  = forward ? s2_sum_reg : data_readRegA;

  hist_add_sat u_add (
    .operand (operand),
    .weight  (s1_weight_reg),
    .sum     (add_sum),
    .ovf     (add_ovf)
  );

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_reg     <= RUN;
      clr_cnt_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s1_bin_reg    <= '0;
      s1_weight_reg <= '0;
      s2_valid_reg  <= 1'b0;
      s2_bin_reg    <= '0;
      s2_sum_reg    <= '0;
      sat_flag_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_bin_reg    <= in_bin;
        s1_weight_reg <= in_weight;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_bin_reg <= s1_bin_reg;
        s2_sum_reg <= add_sum;
      end
      if (clear_done)
        sat_flag_reg <= 1'b0;
      else if (s1_valid_reg && add_ovf)
        sat_flag_reg <= 1'b1;
    end
  end

  // The sweep may start once S2 is guaranteed empty after this edge, i.e. S1 is empty now.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clear_done   = 1'b0;
    case (state_reg)
      RUN: begin
        if (clear_req)
          state_next = s1_valid_reg ? DRAIN : CLEAR;
      end
      DRAIN: begin
        if (!s1_valid_reg)
          state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_reg == bin_t'(NUM_BINS - 1)) begin
          state_next   = RUN;
          clr_cnt_next = '0;
          clear_done   = 1'b1;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = RUN;
        clr_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    ctrl_writeEnable = s2_valid_reg;
    ctrl_writeReg    = s2_bin_reg;
    data_writeReg    = s2_sum_reg;
    if (state_reg == CLEAR) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = clr_cnt_reg;
      data_writeReg    = '0;
    end
  end

  assign ctrl_readRegA = s1_bin_reg;
  assign busy          = (state_reg != RUN) || s1_valid_reg || s2_valid_reg;
  assign sat_flag      = sat_flag_reg;

endmodule

// File: tb/tb_hist_update.sv
// Directed bench for hist_update with a behavioural 32-entry register file
// (falling-edge write, combinational read, shares ctrl_reset).
module tb_hist_update;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_bin = '0;
  logic [7:0]  in_weight = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [4:0]  ctrl_readRegA;
  logic [31:0] data_readRegA;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        sat_flag;

  logic        pre_en = 1'b0;
  logic [31:0] pre_val = '0;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hist_update dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_bin           (in_bin),
    .in_weight        (in_weight),
    .clear_req        (clear_req),
    .busy             (busy),
    .ctrl_readRegA    (ctrl_readRegA),
    .data_readRegA    (data_readRegA),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .sat_flag         (sat_flag)
  );

  always @(negedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pre_en) begin
      rf[0] <= pre_val;
    end else if (ctrl_writeEnable) begin
      rf[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = rf[ctrl_readRegA];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", ctrl_writeEnable); end
    total++; if (ctrl_writeReg !== 5'd0) begin bad++; $display("FAIL reset_wr got=%0d want=0", ctrl_writeReg); end
    total++; if (data_writeReg !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", data_writeReg); end
    total++; if (ctrl_readRegA !== 5'd0) begin bad++; $display("FAIL reset_ra got=%0d want=0", ctrl_readRegA); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
    ctrl_reset = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    $display("reset: released, in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_bin = 5'd3; in_weight = 8'd5;
    step();
    in_valid = 1'b0;
    total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL single_we_early got=%b want=0", ctrl_writeEnable); end
    total++; if (ctrl_readRegA !== 5'd3) begin bad++; $display("FAIL single_ra got=%0d want=3", ctrl_readRegA); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    step();
    total++; if (ctrl_writeEnable !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", ctrl_writeEnable); end
    total++; if (ctrl_writeReg !== 5'd3) begin bad++; $display("FAIL single_wr got=%0d want=3", ctrl_writeReg); end
    total++; if (data_writeReg !== 32'd5) begin bad++; $display("FAIL single_data got=%0d want=5", data_writeReg); end
    step();
    total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL single_we_late got=%b want=0", ctrl_writeEnable); end
    total++; if (rf[3] !== 32'd5) begin bad++; $display("FAIL single_r3 got=%0d want=5", rf[3]); end
    $display("single: bin=3 weight=5 r3=%0d", rf[3]);
  endtask

  task automatic test_zero_weight();
    in_valid = 1'b1; in_bin = 5'd3; in_weight = 8'd0;
    step();
    in_valid = 1'b0;
    step();
    total++; if (ctrl_writeEnable !== 1'b1) begin bad++; $display("FAIL zero_we got=%b want=1", ctrl_writeEnable); end
    total++; if (data_writeReg !== 32'd5) begin bad++; $display("FAIL zero_data got=%0d want=5", data_writeReg); end
    step();
    $display("zero_weight: bin=3 r3=%0d", rf[3]);
  endtask

  task automatic test_forward();
    logic [31:0] exp_w [4];
    int nw;
    exp_w[0] = 32'd1; exp_w[1] = 32'd3; exp_w[2] = 32'd6; exp_w[3] = 32'd10;
    nw = 0;
    in_bin = 5'd7;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_weight = 8'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (ctrl_writeEnable) begin
        if (nw < 4) begin
          total++;
          if (ctrl_writeReg !== 5'd7 || data_writeReg !== exp_w[nw]) begin
            bad++; $display("FAIL fwd_write%0d got=%0d:%0d want=7:%0d", nw, ctrl_writeReg, data_writeReg, exp_w[nw]);
          end
        end
        nw++;
      end
    end
    total++; if (nw != 4) begin bad++; $display("FAIL fwd_count got=%0d want=4", nw); end
    total++; if (rf[7] !== 32'd10) begin bad++; $display("FAIL fwd_r7 got=%0d want=10", rf[7]); end
    $display("forward: bin=7 weights 1..4 writes=%0d r7=%0d", nw, rf[7]);
  endtask

  task automatic test_alternate();
    int nw;
    nw = 0;
    in_weight = 8'd1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_bin = (c % 2 == 0) ? 5'd1 : 5'd2;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (ctrl_writeEnable) nw++;
    end
    total++; if (nw != 8) begin bad++; $display("FAIL alt_count got=%0d want=8", nw); end
    total++; if (rf[1] !== 32'd4) begin bad++; $display("FAIL alt_r1 got=%0d want=4", rf[1]); end
    total++; if (rf[2] !== 32'd4) begin bad++; $display("FAIL alt_r2 got=%0d want=4", rf[2]); end
    $display("alternate: r1=%0d r2=%0d", rf[1], rf[2]);
  endtask

  task automatic test_saturation();
    logic [31:0] exp_r0;
`ifdef HIST_SAT_EN
    exp_r0 = 32'hFFFF_FFFF;
`else
    exp_r0 = 32'h0000_0003;
`endif
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_before got=%b want=0", sat_flag); end
    pre_en = 1'b1; pre_val = 32'hFFFF_FFFE;
    step();
    pre_en = 1'b0;
    in_valid = 1'b1; in_bin = 5'd0; in_weight = 8'd5;
    step();
    in_valid = 1'b0;
    step();
    total++; if (ctrl_writeEnable !== 1'b1 || data_writeReg !== exp_r0) begin
      bad++; $display("FAIL sat_write got=%b:%h want=1:%h", ctrl_writeEnable, data_writeReg, exp_r0);
    end
    step();
    total++; if (rf[0] !== exp_r0) begin bad++; $display("FAIL sat_r0 got=%h want=%h", rf[0], exp_r0); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", sat_flag); end
    $display("saturation: r0=%h sat_flag=%b", rf[0], sat_flag);
  endtask

  task automatic test_clear();
    int  low_cnt, nw, nz;
    bit  done;
    logic [4:0]  exp_bin;
    logic [31:0] exp_dat;
    low_cnt = 0; nw = 0; done = 1'b0;
    in_valid = 1'b1; in_bin = 5'd4; in_weight = 8'd2;
    step();
    in_bin = 5'd5; in_weight = 8'd3;
    step();
    in_valid = 1'b0; clear_req = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (in_ready) begin
        done = 1'b1;
      end else begin
        low_cnt++;
        if (ctrl_writeEnable) begin
          if (nw == 0) begin exp_bin = 5'd4; exp_dat = 32'd2; end
          else if (nw == 1) begin exp_bin = 5'd5; exp_dat = 32'd3; end
          else begin exp_bin = 5'(nw - 2); exp_dat = 32'd0; end
          total++;
          if (nw >= 34 || ctrl_writeReg !== exp_bin || data_writeReg !== exp_dat) begin
            bad++; $display("FAIL clear_write%0d got=%0d:%0d want=%0d:%0d", nw, ctrl_writeReg, data_writeReg, exp_bin, exp_dat);
          end
          nw++;
        end
        step();
        clear_req = 1'b0;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL clear_timeout got=in_ready low want=in_ready high within 100 cycles"); end
    total++; if (low_cnt != 34) begin bad++; $display("FAIL clear_ready_low got=%0d want=34", low_cnt); end
    total++; if (nw != 34) begin bad++; $display("FAIL clear_writes got=%0d want=34", nw); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== 32'd0) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL clear_bins got=%0d nonzero want=0", nz); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL clear_sat got=%b want=0", sat_flag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", busy); end
    $display("clear: in_ready low %0d cycles, %0d writes, nonzero bins=%0d", low_cnt, nw, nz);
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    found = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ctrl_writeEnable && ctrl_writeReg == 5'd10) found = 1'b1;
      else step();
    end
    total++; if (!found) begin bad++; $display("FAIL midclr_reach got=no counter 10 want=counter 10 within 40 cycles"); end
    ctrl_reset = 1'b1;
    #1;
    total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL midclr_we got=%b want=0", ctrl_writeEnable); end
    total++; if (ctrl_writeReg !== 5'd0) begin bad++; $display("FAIL midclr_wr got=%0d want=0", ctrl_writeReg); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b want=0", busy); end
    step();
    ctrl_reset = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midclr_ready got=%b want=1", in_ready); end
    step();
    total++; if (ctrl_writeEnable !== 1'b0) begin bad++; $display("FAIL midclr_we_after got=%b want=0", ctrl_writeEnable); end
    $display("reset_mid_clear: in_ready=%b busy=%b we=%b", in_ready, busy, ctrl_writeEnable);
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_weight();
    test_forward();
    test_alternate();
    test_saturation();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hist_update.md
Name: hist_update

Overview:
- Read-modify-write front end for the 32-entry histogram register file.
- Accepts a stream of (bin, weight) samples and reads the current count through the file's A read port.
- Adds the weight and writes the result back through the file's write port.
- Also runs a full clear sweep on request; sits directly upstream of the register file.

Parameters:
- NUM_BINS, 32, number of bins; must match the register-file depth; index width BIN_W = $clog2(NUM_BINS) = 5.
- DATA_W, 32, count width; must match the register-file data width.
- WEIGHT_W, 8, sample weight width; zero-extended to DATA_W before the add.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_bin  input  BIN_W  target bin index.
- in_weight  input  WEIGHT_W  increment amount.
- clear_req  input  1  level request to zero all bins.
- busy  output  1  high in DRAIN or CLEAR, or while the pipeline holds valid work.
- ctrl_readRegA  output  BIN_W  read index to the register file.
- data_readRegA  input  DATA_W  combinational read data from the register file.
- ctrl_writeEnable  output  1  register-file write strobe.
- ctrl_writeReg  output  BIN_W  register-file write index.
- data_writeReg  output  DATA_W  register-file write data.
- sat_flag  output  1  sticky flag: an add overflowed (see Optional Feature).

Behaviour:
- Reset:
  - All pipeline valids = 0, state = RUN, clear counter = 0, sat_flag = 0.
  - Outputs: ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, ctrl_readRegA = 0, busy = 0.
  - in_ready = 1 once reset deasserts.
  - The register file shares ctrl_reset, so its contents are zero as well.
- Handshake:
  - A sample transfers on a rising edge with in_valid && in_ready.
  - in_ready = (state == RUN) && !clear_req.
  - No backpressure from the register file; throughput is 1 sample per cycle.
- Pipeline:
  - S1 (read): registered bin/weight/valid; ctrl_readRegA = S1 bin.
  - S1 operand = forward ? S2 data : data_readRegA, where forward = S1.valid && S2.valid && S1.bin == S2.bin.
  - S1 sum = operand + zero-extended weight.
  - S2 (write): registered sum/bin/valid.
  - ctrl_writeEnable = S2.valid, ctrl_writeReg = S2.bin, data_writeReg = S2 sum. The register file captures the write on the falling edge.
  - Latency: sample accepted at edge k; write strobe high during cycle k+2; count readable after the falling edge of cycle k+2.
  - Back-to-back hits to the same bin must accumulate exactly (forwarding is mandatory). Weight 0 still performs the write.
- State machine:
  - RUN -> DRAIN when clear_req is high; DRAIN -> CLEAR once S1 and S2 are both empty. If the pipeline is already empty, go straight to CLEAR.
  - CLEAR: writeEnable = 1, writeReg = counter, data = 0; counter increments each cycle.
  - CLEAR -> RUN after counter == NUM_BINS-1 is written (exactly NUM_BINS cycles). The counter returns to 0.
  - clear_req that is still high on return to RUN starts a new sweep; clear_req deasserting mid-CLEAR does not abort the sweep.
- Reset during any state immediately returns to RUN with empty pipeline; no partial write is issued after reset.
- in_bin >= NUM_BINS is impossible while NUM_BINS = 32. For other values it is not defined: the sample is dropped and no write occurs.

Optional Feature:
- Macro HIST_SAT_EN.
- Defined: sums that exceed 2^DATA_W-1 clamp to all ones, and sat_flag sets.
- Not defined: sums wrap modulo 2^DATA_W, and sat_flag also sets on carry-out.
- sat_flag clears only on reset or on completion of a CLEAR sweep.

Decomposition:
- Shared package hist_pkg:
  - constants NUM_BINS, BIN_W, DATA_W;
  - typedef bin_t;
  - typedef count_t;
  - enum upd_state_t {RUN, DRAIN, CLEAR}.
- One natural sub-module: hist_add_sat (combinational operand + weight with the overflow/saturation logic, selected by HIST_SAT_EN).
- The forwarding mux and the FSM stay in the top module.

Test Plan:
- Reset, then a single sample bin=3 weight=5 -> writeEnable high exactly 2 cycles later with writeReg=3, data=5; r3 reads 5.
- Four consecutive samples to bin 7, weights 1,2,3,4, in_valid held -> writes of 1, 3, 6, 10; final r7 = 10 (exercises forwarding).
- Alternating bins 1/2/1/2, weight 1, for 8 cycles -> r1 = 4, r2 = 4; no lost updates.
- Preload bin 0 to 0xFFFF_FFFE, add weight 5:
  - with HIST_SAT_EN: r0 = 0xFFFF_FFFF and sat_flag = 1;
  - without: r0 = 0x0000_0003 and sat_flag = 1.
- clear_req pulsed with 2 samples in flight -> both writes complete, then 32 zero writes to bins 0..31; in_ready stays low for 34 cycles; all bins read 0.
- ctrl_reset asserted mid-CLEAR at counter=10 -> all outputs 0 next cycle, state RUN, in_ready = 1 after release.
